// File: rtl/multi_port_lutram_pkg.sv
// Shared definitions for the multi-port LUTRAM slice.
//   BYTE_LEN_IN_BITS  : width of one byte lane covered by a write enable bit
//   FULL/HALF_CYCLE_DELAY : reference clock timing for simulation benches
//   lutram_state_e    : clear-sweep / ready state encoding
package multi_port_lutram_pkg;

  localparam int unsigned BYTE_LEN_IN_BITS = 8;
  localparam int unsigned FULL_CYCLE_DELAY = 10;
  localparam int unsigned HALF_CYCLE_DELAY = 5;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } lutram_state_e;

endpackage

// File: rtl/multi_port_lutram_read_port_pipe.sv
// One read port's output pipeline for multi_port_lutram.
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   req           : read request already qualified by the READY state
//   mem_word      : raw (pre-write) memory word at this port's address
//   collision     : this port's address matches an active write this cycle
//   write_mask    : byte enables of the concurrent write
//   write_data    : data of the concurrent write
//   data, valid   : read data / valid after READ_LATENCY stages
module lutram_read_port_pipe
  import multi_port_lutram_pkg::*;
#(
  parameter int unsigned ENTRY_WIDTH  = 64,
  parameter int unsigned MASK_LEN     = ENTRY_WIDTH / BYTE_LEN_IN_BITS,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WRITE_FIRST  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic [ENTRY_WIDTH-1:0] mem_word,
  input  logic                   collision,
  input  logic [MASK_LEN-1:0]    write_mask,
  input  logic [ENTRY_WIDTH-1:0] write_data,
  output logic [ENTRY_WIDTH-1:0] data,
  output logic                   valid
);

  logic [ENTRY_WIDTH-1:0]  merged;
  logic [ENTRY_WIDTH-1:0]  selected;
  logic [ENTRY_WIDTH-1:0]  data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_q;

  // Byte-wise merge of the write into the old word: what the entry holds
  // after this edge. Used only for the write-first collision policy.
  always_comb begin
    merged = mem_word;
    for (int unsigned i = 0; i < MASK_LEN; i++) begin
      if (write_mask[i]) begin
        merged[i*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] =
          write_data[i*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
      end
    end
  end

  always_comb begin
    selected = mem_word;
    if ((WRITE_FIRST != 0) && collision) begin
      selected = merged;
    end
  end

  // Each stage only loads when the stage before it holds a valid word, so
  // the output data holds its last value while valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= req;
      if (req) begin
        data_q[0] <= selected;
      end
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign data  = data_q[READ_LATENCY-1];
  assign valid = valid_q[READ_LATENCY-1];

endmodule

// File: rtl/multi_port_lutram.sv
// Multi-port LUTRAM: one byte-masked write port, NUM_READ_PORT read ports,
// READ_LATENCY of 1 or 2, selectable write-first/read-first collisions and
// a hardware clear sweep after reset.
//   clk_in, reset_in   : rising-edge clock, synchronous active-high reset
//   write_en_in        : byte enables (bit i -> bits 8i+7:8i)
//   write_set_addr_in  : write address
//   write_entry_in     : write data
//   read_en_in         : per-port read request
//   read_set_addr_in   : packed read addresses, port p in slice p
//   read_entry_out     : packed read data, port p in slice p
//   read_valid_out     : per-port read valid
//   init_done_out      : high once every entry has been cleared
module multi_port_lutram
  import multi_port_lutram_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned NUM_SET                    = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int unsigned NUM_READ_PORT              = 2,
  parameter int unsigned READ_LATENCY               = 1,
  parameter int unsigned WRITE_FIRST                = 1,
  parameter int unsigned WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  input  logic [WRITE_MASK_LEN-1:0]                           write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                    write_set_addr_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               write_entry_in,
  input  logic [NUM_READ_PORT-1:0]                            read_en_in,
  input  logic [NUM_READ_PORT*SET_PTR_WIDTH_IN_BITS-1:0]      read_set_addr_in,
  output logic [NUM_READ_PORT*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_entry_out,
  output logic [NUM_READ_PORT-1:0]                            read_valid_out,
  output logic                                                init_done_out
);

  localparam int unsigned W  = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int unsigned AW = SET_PTR_WIDTH_IN_BITS;
  localparam logic [AW-1:0] LAST_SET = AW'(NUM_SET - 1);

  logic [W-1:0]  mem [NUM_SET];

  lutram_state_e state_q, state_d;
  logic [AW-1:0] clear_ptr_q, clear_ptr_d;
  logic          init_done_q, init_done_d;
  logic          ready;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= ST_INIT;
      clear_ptr_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == LAST_SET) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign ready         = (state_q == ST_READY);
  assign init_done_out = init_done_q;

  // Memory is deliberately outside the reset branch: reset only restarts
  // the sweep, it never touches stored contents directly.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      if (!ready) begin
        mem[clear_ptr_q] <= '0;
      end else begin
        for (int unsigned i = 0; i < WRITE_MASK_LEN; i++) begin
          if (write_en_in[i]) begin
            mem[write_set_addr_in][i*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] <=
              write_entry_in[i*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_READ_PORT; p++) begin : g_read_port
    logic [AW-1:0] addr;
    logic          collision;

    assign addr      = read_set_addr_in[p*AW +: AW];
    assign collision = (addr == write_set_addr_in) && (|write_en_in);

    lutram_read_port_pipe #(
      .ENTRY_WIDTH (W),
      .MASK_LEN    (WRITE_MASK_LEN),
      .READ_LATENCY(READ_LATENCY),
      .WRITE_FIRST (WRITE_FIRST)
    ) u_pipe (
      .clk       (clk_in),
      .reset     (reset_in),
      .req       (read_en_in[p] && ready),
      .mem_word  (mem[addr]),
      .collision (collision),
      .write_mask(write_en_in),
      .write_data(write_entry_in),
      .data      (read_entry_out[p*W +: W]),
      .valid     (read_valid_out[p])
    );
  end

endmodule

// File: tb/tb_multi_port_lutram.sv
// Self-checking bench for multi_port_lutram. Three instances share one
// stimulus stream: default (write-first, latency 1), read-first, latency 2.
module tb_multi_port_lutram;
  import multi_port_lutram_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   wen = '0;
  logic [5:0]   waddr = '0;
  logic [63:0]  wdata = '0;
  logic [1:0]   ren = '0;
  logic [5:0]   ra0 = '0, ra1 = '0;

  logic [127:0] d_a, d_rf, d_l2;
  logic [1:0]   v_a, v_rf, v_l2;
  logic         done_a, done_rf, done_l2;

  int checks = 0;
  int errors = 0;

  always #(HALF_CYCLE_DELAY) clk = ~clk;

  multi_port_lutram dut_a (
    .clk_in(clk), .reset_in(reset), .write_en_in(wen), .write_set_addr_in(waddr),
    .write_entry_in(wdata), .read_en_in(ren), .read_set_addr_in({ra1, ra0}),
    .read_entry_out(d_a), .read_valid_out(v_a), .init_done_out(done_a));

  multi_port_lutram #(.WRITE_FIRST(0)) dut_rf (
    .clk_in(clk), .reset_in(reset), .write_en_in(wen), .write_set_addr_in(waddr),
    .write_entry_in(wdata), .read_en_in(ren), .read_set_addr_in({ra1, ra0}),
    .read_entry_out(d_rf), .read_valid_out(v_rf), .init_done_out(done_rf));

  multi_port_lutram #(.READ_LATENCY(2)) dut_l2 (
    .clk_in(clk), .reset_in(reset), .write_en_in(wen), .write_set_addr_in(waddr),
    .write_entry_in(wdata), .read_en_in(ren), .read_set_addr_in({ra1, ra0}),
    .read_entry_out(d_l2), .read_valid_out(v_l2), .init_done_out(done_l2));

  typedef struct {
    logic [7:0]  wen;
    logic [5:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  ren;
    logic [5:0]  ra0;
    logic [5:0]  ra1;
    logic [1:0]  ev;
    logic [63:0] e0;
    logic [63:0] e1;
    logic [63:0] erf;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    logic bad_valid;
    logic [1:0]  lv [6];
    logic [63:0] ld [6];

    vecs[0] = '{8'hFF, 6'd63, 64'hFFFFFFFF_00000000, 2'b00, 6'd0,  6'd0,  2'b00,
                64'h0, 64'h0, 64'h0};
    vecs[1] = '{8'h00, 6'd0,  64'h0, 2'b11, 6'd63, 6'd63, 2'b11,
                64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000};
    vecs[2] = '{8'hFF, 6'd62, 64'h0, 2'b00, 6'd0,  6'd0,  2'b00,
                64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000};
    vecs[3] = '{8'hCC, 6'd62, 64'hFFFFFFFF_FFFFFFFF, 2'b00, 6'd0, 6'd0, 2'b00,
                64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000};
    vecs[4] = '{8'h00, 6'd0,  64'h0, 2'b11, 6'd62, 6'd63, 2'b11,
                64'hFFFF0000_FFFF0000, 64'hFFFFFFFF_00000000, 64'hFFFF0000_FFFF0000};
    vecs[5] = '{8'h0F, 6'd10, 64'h1111_2222_3333_4444, 2'b11, 6'd10, 6'd10, 2'b11,
                64'h0000_0000_3333_4444, 64'h0000_0000_3333_4444, 64'h0};
    vecs[6] = '{8'h00, 6'd0,  64'h0, 2'b11, 6'd5,  6'd10, 2'b11,
                64'h0, 64'h0000_0000_3333_4444, 64'h0};
    vecs[7] = '{8'h00, 6'd0,  64'h0, 2'b01, 6'd63, 6'd5,  2'b01,
                64'hFFFFFFFF_00000000, 64'h0000_0000_3333_4444, 64'hFFFFFFFF_00000000};
    vecs[8] = '{8'hF0, 6'd10, 64'hAAAA_BBBB_CCCC_DDDD, 2'b11, 6'd10, 6'd62, 2'b11,
                64'hAAAA_BBBB_3333_4444, 64'hFFFF0000_FFFF0000, 64'h0000_0000_3333_4444};

    // Reset state.
    repeat (3) tick();
    chk("rst_init_done", {125'h0, done_a, done_rf, done_l2}, 128'h0);
    chk("rst_valid", {122'h0, v_a, v_rf, v_l2}, 128'h0);
    chk("rst_data_a", d_a, 128'h0);
    chk("rst_data_l2", d_l2, 128'h0);

    // Sweep interrupted at cycle 20; write and reads during INIT are ignored.
    reset = 1'b0;
    wen = 8'hFF; waddr = 6'd5; wdata = 64'hAB;
    ren = 2'b11; ra0 = 6'd5; ra1 = 6'd5;
    bad_valid = 1'b0;
    repeat (20) begin
      tick();
      if ((v_a | v_rf | v_l2) != 2'b00) bad_valid = 1'b1;
    end
    chk("sweep20_init_done", {127'h0, done_a}, 128'h0);
    reset = 1'b1;
    tick();
    chk("midreset_init_done", {127'h0, done_a}, 128'h0);
    reset = 1'b0;
    n = 0;
    while (!done_a && n < 200) begin
      tick();
      n++;
      if ((v_a | v_rf | v_l2) != 2'b00) bad_valid = 1'b1;
    end
    wen = '0;
    chk("init_cycles", 128'(n), 128'd64);
    chk("init_done_all", {125'h0, done_a, done_rf, done_l2}, 128'h7);
    chk("init_no_valid", {127'h0, bad_valid}, 128'h0);

    // First reads after the sweep: cleared entries, dropped INIT write.
    ren = 2'b11; ra0 = 6'd63; ra1 = 6'd5;
    tick();
    chk("first_read_valid", {126'h0, v_a}, 128'h3);
    chk("first_read_data", d_a, 128'h0);
    chk("first_read_l2_not_yet", {126'h0, v_l2}, 128'h0);

    // Table: latency-1 instances, one row per clock.
    for (int i = 0; i < 9; i++) begin
      wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      ren = vecs[i].ren; ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
      tick();
      chk($sformatf("vec%0d_valid", i), {126'h0, v_a}, {126'h0, vecs[i].ev});
      chk($sformatf("vec%0d_data0", i), {64'h0, d_a[63:0]}, {64'h0, vecs[i].e0});
      chk($sformatf("vec%0d_data1", i), {64'h0, d_a[127:64]}, {64'h0, vecs[i].e1});
      chk($sformatf("vec%0d_rf_data0", i), {64'h0, d_rf[63:0]}, {64'h0, vecs[i].erf});
    end

    // Latency-2 pipelining: preload 1,2,3 then back-to-back reads.
    ren = '0;
    for (int a = 1; a <= 3; a++) begin
      wen = 8'hFF; waddr = 6'(a); wdata = 64'(a);
      tick();
    end
    wen = '0;
    lv = '{2'b0, 2'b1, 2'b1, 2'b1, 2'b0, 2'b0};
    ld = '{64'h0, 64'd1, 64'd2, 64'd3, 64'd3, 64'd3};
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        ren = 2'b01; ra0 = 6'(k + 1);
      end else begin
        ren = 2'b00;
      end
      tick();
      chk($sformatf("lat2_valid_%0d", k), {127'h0, v_l2[0]}, {126'h0, lv[k]});
      if (k >= 1) chk($sformatf("lat2_data_%0d", k), {64'h0, d_l2[63:0]}, {64'h0, ld[k]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_port_lutram.md
Name: multi_port_lutram

Overview:
- Parametrised successor to the single-port LUTRAM: one byte-masked write port plus NUM_READ_PORT independent read ports.
- Read latency is configurable, and a write-first/read-first collision policy is selectable.
- A hardware clear sweep zeroes every entry after reset.
- Used as a register-file / tag-array building block where several consumers read the same table each cycle.

Parameters:
- SINGLE_ENTRY_WIDTH_IN_BITS, 64, entry width; must be a multiple of `BYTE_LEN_IN_BITS.
- NUM_SET, 64, number of entries; must be ≥ 2.
- SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), address width.
- NUM_READ_PORT, 2, number of independent read ports, ≥ 1.
- READ_LATENCY, 1, cycles from address sample to data; legal values 1 or 2.
- WRITE_FIRST, 1, collision policy: 1 returns merged new data, 0 returns old data.
- WRITE_MASK_LEN, SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS, number of byte-enable bits.

Ports:
- clk_in  input  1  clock, rising edge.
- reset_in  input  1  synchronous, active-high reset.
- write_en_in  input  WRITE_MASK_LEN  byte write enables; bit i covers byte i (bits 8i+7:8i).
- write_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  write address.
- write_entry_in  input  SINGLE_ENTRY_WIDTH_IN_BITS  write data.
- read_en_in  input  NUM_READ_PORT  per-port read request.
- read_set_addr_in  input  NUM_READ_PORT*SET_PTR_WIDTH_IN_BITS  packed addresses; port p uses slice p.
- read_entry_out  output  NUM_READ_PORT*SINGLE_ENTRY_WIDTH_IN_BITS  packed read data.
- read_valid_out  output  NUM_READ_PORT  per-port data valid.
- init_done_out  output  1  high once the clear sweep has completed.

Behaviour:
- Reset
  - Any posedge with reset_in=1 sets FSM=INIT, clear_ptr=0, init_done_out=0, all read_valid_out=0, all read_entry_out=0, and flushes the pipeline stages.
  - Memory contents are not touched by reset itself.
- FSM INIT
  - Each posedge with reset_in=0 writes mem[clear_ptr]<=0 and increments clear_ptr.
  - When clear_ptr==NUM_SET-1, the FSM moves to READY and init_done_out<=1.
  - init_done_out is therefore high after exactly NUM_SET non-reset posedges.
  - In INIT, write_en_in and read_en_in are ignored and read_valid_out stays 0.
  - Reset asserted mid-sweep restarts the sweep from 0.
- FSM READY
  - Stays in READY until reset_in; there are no other transitions.
- Write
  - At a posedge in READY, each byte i with write_en_in[i]=1 updates mem[write_set_addr_in] byte i. Other bytes are unchanged.
  - write_en_in=0 is a no-op.
- Read
  - At posedge T in READY with read_en_in[p]=1, slice p's address is sampled.
  - With READ_LATENCY=1, read_entry_out[p] and read_valid_out[p]=1 are visible after T; with READ_LATENCY=2, after posedge T+1.
  - read_valid_out[p] is a pure delayed copy of the request; there is no backpressure.
  - When read_en_in[p]=0, valid drops and data holds its last value.
- Collision (read address == write address at the same posedge)
  - WRITE_FIRST=1: returned data is the byte-wise merge, written bytes new and unwritten bytes old.
  - WRITE_FIRST=0: returned data is the pre-write entry.
  - Multiple read ports at the same address all return identical data.
- Pipeline
  - Ports are fully pipelined: one request per port per cycle, with back-to-back reads at any address.

Decomposition:
- `BYTE_LEN_IN_BITS, `FULL_CYCLE_DELAY and `HALF_CYCLE_DELAY come from the shared parameters.h.
- FSM state encodings (INIT, READY) go in the same shared header as localparam-style defines.
- Natural sub-module: lutram_read_port_pipe, one instance per port. It takes the raw mem word plus the collision bypass and provides the READ_LATENCY stages for data and valid. It is instantiated in a generate loop.

Test Plan (defaults unless stated):
1. Init sweep: deassert reset and count posedges → init_done_out rises after exactly 64. Read addr 63 → 0, with valid one cycle after the request.
2. Full write/read: write addr 63 with mask 8'hFF, data 64'hFFFFFFFF_00000000. Next cycle read addr 63 on ports 0 and 1 → both return 64'hFFFFFFFF_00000000 with valid=1.
3. Byte mask: write addr 62 with all 0s and mask 8'hFF. Then write all 1s with mask 8'b11001100 → read returns 64'hFFFF0000_FFFF0000.
4. Collision: addr 10 holds 64'h0. In the same cycle write 64'h1111_2222_3333_4444 with mask 8'h0F and read addr 10.
   - WRITE_FIRST=1 → 64'h0000_0000_3333_4444.
   - Rerun with WRITE_FIRST=0 → 64'h0.
5. Latency/pipelining with READ_LATENCY=2: issue reads to addrs 1, 2, 3 on consecutive cycles (preloaded 1, 2, 3) → outputs 1, 2, 3 on consecutive cycles, each two posedges after its request, with valid high for exactly three cycles.
6. Reset mid-sweep: assert reset at sweep cycle 20 for one cycle → init_done_out stays 0, then rises 64 posedges after release. A write attempted during INIT (addr 5, 64'hAB, mask 8'hFF) is dropped; addr 5 reads 0 afterwards.
